// File: rtl/mult_sched_pkg.sv
// Shared state encoding and sizing helpers for the multiplier-engine scheduler.
package mult_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ABORT = 3'd4
    } sched_state_e;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int timer_width(input int t);
        return (t > 0) ? $clog2(t + 1) : 1;
    endfunction

endpackage

// File: rtl/mult_sched_rr_pick.sv
// Round-robin picker: first asserted request at or above ptr, wrapping to bit 0.
module rr_pick
    import mult_sched_pkg::*;
#(
    parameter  int NREQ  = 4,
    localparam int SEL_W = sel_width(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    int scan_pos;

    // Scan from the farthest position back toward ptr so the closest hit is written last.
    always_comb begin
        any      = |req;
        idx      = ptr;
        scan_pos = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            scan_pos = (int'(ptr) + i) % NREQ;
            idx      = req[scan_pos] ? SEL_W'(scan_pos) : idx;
        end
    end

endmodule

// File: rtl/mult_sched.sv
// Shares one multiplier engine between NREQ requesters: round-robin grant,
// one-cycle start, completion on the engine's Done rising edge, abort on timeout.
module mult_sched
    import mult_sched_pkg::*;
#(
    parameter  int NREQ    = 4,
    parameter  int TIMEOUT = 1023,
    localparam int SEL_W   = sel_width(NREQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic [NREQ-1:0]  ack,
    output logic [NREQ-1:0]  err,
    output logic             mult_start,
    output logic             mult_abort,
    input  logic             mult_done,
    output logic             busy,
    output logic [SEL_W-1:0] cur_sel
);

    localparam int               TMR_W     = timer_width(TIMEOUT);
    localparam logic [TMR_W-1:0] TIMEOUT_V = TMR_W'(TIMEOUT);
    localparam logic [TMR_W-1:0] TIMER_MAX = {TMR_W{1'b1}};
    localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(NREQ - 1);
    localparam logic [NREQ-1:0]  ONE_HOT_0 = {{(NREQ-1){1'b0}}, 1'b1};

    sched_state_e     state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             done_q, done_d;

    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NREQ-1:0]  ack_q, ack_d;
    logic [NREQ-1:0]  err_q, err_d;
    logic             mult_start_q, mult_start_d;
    logic             mult_abort_q, mult_abort_d;
    logic             busy_q, busy_d;

    logic             pick_any_s;
    logic [SEL_W-1:0] pick_idx_s;
    logic             done_edge_s;
    logic [TMR_W-1:0] timer_inc_s;
    logic [SEL_W-1:0] ptr_next_s;
    logic [NREQ-1:0]  sel_onehot_s;

    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req (req),
        .ptr (ptr_q),
        .any (pick_any_s),
        .idx (pick_idx_s)
    );

    // Done edge detect, saturating timer increment and pointer advance past the grantee.
    always_comb begin
        done_d      = mult_done;
        done_edge_s = mult_done & ~done_q;
        if (timer_q == TIMER_MAX) begin
            timer_inc_s = timer_q;
        end else begin
            timer_inc_s = timer_q + TMR_W'(1);
        end
        if (sel_q == SEL_LAST) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = sel_q + SEL_W'(1);
        end
    end

    // Next-state logic; a Done edge in the final WAIT cycle wins over the timeout.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        timer_d = timer_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any_s) begin
                    sel_d   = pick_idx_s;
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                timer_d = timer_inc_s;
                if (done_edge_s) begin
                    state_d = ST_DONE;
                end else if (timer_inc_s == TIMEOUT_V) begin
                    state_d = ST_ABORT;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE, ST_ABORT: begin
                ptr_d   = ptr_next_s;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so every port comes straight from a flop.
    always_comb begin
        gnt_d        = '0;
        ack_d        = '0;
        err_d        = '0;
        mult_start_d = 1'b0;
        mult_abort_d = 1'b0;
        busy_d       = 1'b0;
        sel_onehot_s = ONE_HOT_0 << sel_d;
        case (state_d)
            ST_IDLE: begin
                busy_d = 1'b0;
            end
            ST_START: begin
                gnt_d        = sel_onehot_s;
                mult_start_d = 1'b1;
                busy_d       = 1'b1;
            end
            ST_WAIT: begin
                gnt_d  = sel_onehot_s;
                busy_d = 1'b1;
            end
            ST_DONE: begin
                gnt_d  = sel_onehot_s;
                ack_d  = sel_onehot_s;
                busy_d = 1'b1;
            end
            ST_ABORT: begin
                gnt_d        = sel_onehot_s;
                err_d        = sel_onehot_s;
                mult_abort_d = 1'b1;
                busy_d       = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // State, bookkeeping and output registers; reset drops any job in flight silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sel_q        <= '0;
            ptr_q        <= '0;
            timer_q      <= '0;
            done_q       <= 1'b0;
            gnt_q        <= '0;
            ack_q        <= '0;
            err_q        <= '0;
            mult_start_q <= 1'b0;
            mult_abort_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            ptr_q        <= ptr_d;
            timer_q      <= timer_d;
            done_q       <= done_d;
            gnt_q        <= gnt_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            mult_start_q <= mult_start_d;
            mult_abort_q <= mult_abort_d;
            busy_q       <= busy_d;
        end
    end

    assign gnt        = gnt_q;
    assign ack        = ack_q;
    assign err        = err_q;
    assign mult_start = mult_start_q;
    assign mult_abort = mult_abort_q;
    assign busy       = busy_q;
    assign cur_sel    = sel_q;

endmodule

// File: tb/tb_mult_sched.sv
// Self-checking bench for mult_sched: directed corner cases plus randomized jobs
// checked cycle by cycle against a transaction-level timing model.
module tb_mult_sched;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 15;
    localparam int BIG     = 1000;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [3:0] ack;
    logic [3:0] err;
    logic       mult_start;
    logic       mult_abort;
    logic       mult_done;
    logic       busy;
    logic [1:0] cur_sel;

    int n_cmp = 0;
    int n_bad = 0;
    int m_ptr = 0;

    mult_sched #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .gnt        (gnt),
        .ack        (ack),
        .err        (err),
        .mult_start (mult_start),
        .mult_abort (mult_abort),
        .mult_done  (mult_done),
        .busy       (busy),
        .cur_sel    (cur_sel)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Round-robin reference: first requester at or after the model pointer.
    function automatic int model_pick(input logic [3:0] rq);
        for (int i = 0; i < NREQ; i++) begin
            if (rq[(m_ptr + i) % NREQ]) return (m_ptr + i) % NREQ;
        end
        return 0;
    endfunction

    // Engine Done level in cycle t of a job (t=0 is the START cycle, t<0 before it).
    function automatic logic dlev(input int t, input logic init, input int lo_at,
                                  input int hi_at, input int plen);
        if (t < lo_at)             return init;
        else if (t < hi_at)        return 1'b0;
        else if (t < hi_at + plen) return 1'b1;
        else                       return 1'b0;
    endfunction

    // One job: request, expected grant, Done waveform, expected ack/err cycle, release.
    task automatic do_job(input logic [3:0] rq, input int lo_at, input int hi_at,
                          input int plen, input int drop_at);
        int         sel;
        int         edge_t;
        int         end_t;
        logic       init;
        logic [3:0] oh;
        bit         is_ack;
        @(negedge clk);
        req    = rq;
        init   = mult_done;
        sel    = model_pick(rq);
        oh     = 4'b0001 << sel;
        edge_t = -1;
        for (int t = 1; t <= TIMEOUT; t++) begin
            if (edge_t < 0 && dlev(t, init, lo_at, hi_at, plen) && !dlev(t - 1, init, lo_at, hi_at, plen))
                edge_t = t;
        end
        is_ack = (edge_t > 0);
        end_t  = is_ack ? edge_t + 1 : TIMEOUT + 1;
        @(posedge clk); #1;
        for (int t = 0; t <= end_t + 1; t++) begin
            check_eq("gnt",        gnt,        (t <= end_t) ? oh : 4'b0000);
            check_eq("mult_start", mult_start, t == 0);
            check_eq("ack",        ack,        (t == end_t && is_ack) ? oh : 4'b0000);
            check_eq("err",        err,        (t == end_t && !is_ack) ? oh : 4'b0000);
            check_eq("mult_abort", mult_abort, t == end_t && !is_ack);
            check_eq("busy",       busy,       t <= end_t);
            check_eq("cur_sel",    cur_sel,    sel);
            if (t <= end_t) begin
                @(negedge clk);
                mult_done = dlev(t, init, lo_at, hi_at, plen);
                if (t == drop_at || t == end_t) req = 4'b0000;
                @(posedge clk); #1;
            end
        end
        m_ptr = (sel + 1) % NREQ;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_gnt"},   gnt,        4'b0000);
        check_eq({tag, "_ack"},   ack,        4'b0000);
        check_eq({tag, "_err"},   err,        4'b0000);
        check_eq({tag, "_start"}, mult_start, 1'b0);
        check_eq({tag, "_abort"}, mult_abort, 1'b0);
        check_eq({tag, "_busy"},  busy,       1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req       = 4'b0000;
        mult_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_quiet("reset");
        check_eq("reset_cur_sel", cur_sel, 2'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // All requesting: eight jobs rotate 0,1,2,3,0,1,2,3.
        for (int j = 0; j < 8; j++) do_job(4'b1111, 0, 3 + j, 1, -1);

        // Single requester with a short Done pulse.
        do_job(4'b0001, 0, 10, 1, -1);

        // Stale level Done: left high, then low three cycles, then a genuine rise.
        do_job(4'b0010, 0, 2, BIG, -1);
        do_job(4'b0010, 3, 6, BIG, -1);
        do_job(4'b0100, 0, 2, 1, -1);

        // Timeout with no Done, then a late Done that must be ignored.
        do_job(4'b0001, 0, BIG, 1, -1);
        @(negedge clk);
        mult_done = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check_quiet("late_done");
        end
        @(negedge clk);
        mult_done = 1'b0;
        do_job(4'b0011, 0, 4, 1, -1);

        // Done edge on the last WAIT cycle beats the timeout; one cycle later it loses.
        do_job(4'b0100, 0, TIMEOUT, 1, -1);
        do_job(4'b1000, 0, TIMEOUT + 1, 1, -1);

        // Requester drops req mid-WAIT; ack still pulses.
        do_job(4'b0010, 0, 6, 1, 2);

        // Reset mid-WAIT while pointer sits at 3.
        do_job(4'b0100, 0, 3, 1, -1);
        @(negedge clk);
        req = 4'b1000;
        @(posedge clk); #1;
        check_eq("pre_rst_gnt", gnt, 4'b1000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        req = 4'b0000;
        @(posedge clk); #1;
        check_quiet("mid_rst");
        check_eq("mid_rst_cur_sel", cur_sel, 2'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            check_quiet("post_rst");
        end
        m_ptr = 0;
        do_job(4'b1001, 0, 5, 1, -1);
        do_job(4'b0100, 0, 4, 1, -1);

        // Randomized jobs: request mix, Done timing/shape, stale levels, mid-job drops.
        for (int j = 0; j < 40; j++) begin
            logic [3:0] rq;
            int         lo;
            int         hi;
            int         pl;
            int         dr;
            rq = 4'($urandom_range(1, 15));
            lo = mult_done ? int'($urandom_range(0, 3)) : 0;
            hi = lo + int'($urandom_range(1, TIMEOUT + 3));
            pl = ($urandom_range(0, 1) == 1) ? 1 : BIG;
            dr = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6)) : -1;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            do_job(rq, lo, hi, pl, dr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
